cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Sequencing controller for the direct-mapped, write-back, write-allocate cache array (the 64-line × 4-word array with registered read outputs).
- Sits between the CPU load/store port and the main-memory bus.
- On a hit, services the access from the array.
- On a miss, writes back a dirty victim line word by word, refills the line from memory, re-checks the tag, then completes the access.

Parameters:
ADDR_BITS, 32, address width
WORD_BITS, 32, data word width
TAG_BITS, 22, tag field width = ADDR_BITS-LINE_INDEX_WIDTH-LINE_WORDS_WIDTH-WORD_BYTES_WIDTH
WORD_BYTES_WIDTH, 2, byte-offset bits
LINE_WORDS_WIDTH, 2, word-in-line bits; LINE_WORDS = 2**LINE_WORDS_WIDTH = 4
LINE_INDEX_WIDTH, 6, line-index bits (64 lines)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
cpu_req  in  1  access request; held until cpu_ack
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_BITS  byte address, word aligned
cpu_din  in  WORD_BITS  store data
cpu_dout  out  WORD_BITS  load data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  1 whenever state != IDLE
cache_addr  out  ADDR_BITS  array address
cache_store  out  1  array store strobe (write word, valid=1, dirty=0, tag update)
cache_edit  out  1  array edit strobe (write word, dirty=1)
cache_invalid  out  1  array invalidate strobe; tied 0 in this revision
cache_din  out  WORD_BITS  array write data
cache_hit  in  1  array hit (tag match && registered valid)
cache_dout  in  WORD_BITS  array read data, registered, 1 cycle after cache_addr
cache_valid  in  1  registered valid of indexed line
cache_dirty  in  1  registered dirty of indexed line
cache_tag  in  TAG_BITS  registered tag of indexed line
mem_cs  out  1  memory request; held until mem_ack
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_BITS  memory word address
mem_dout  out  WORD_BITS  memory write data
mem_din  in  WORD_BITS  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle; ignored while mem_cs=0

Behaviour:
- Reset: state=IDLE, word counter k=0, latches cleared.
  - cpu_ack, cpu_dout, cache_store, cache_edit, cache_invalid, mem_cs, mem_we all 0; cache_din, mem_addr, mem_dout = 0.
  - Reset mid-operation aborts at once; no array strobe is issued in the reset cycle; mem_cs=0 from the following cycle.
- Request latch: in IDLE with cpu_req=1, latch addr/we/din (A, W, D) and go to TAG.
  - cpu_req changes after the latch are ignored until cpu_ack.
- cache_addr:
  - IDLE: cpu_addr.
  - TAG and RWAIT: A.
  - WB_RD, WB_WR, ALLOC: {A.tag-or-victim-tag, A.index, k, zeros}.
- TAG: array outputs reflect A.
  - Hit, load: cpu_dout<=cache_dout, cpu_ack=1, go to IDLE. Hit latency is 2 cycles from cpu_req to cpu_ack.
  - Hit, store: cache_edit=1, cache_din=D, cpu_ack=1, go to IDLE.
  - Miss with cache_valid&&cache_dirty: latch victim tag VT=cache_tag, k=0, go to WB_RD.
  - Other miss: k=0, go to ALLOC.
- WB_RD: array address = {idx, k}; one-cycle read wait; go to WB_WR.
- WB_WR: mem_cs=1, mem_we=1, mem_addr={VT, idx, k, 0}, mem_dout=cache_dout (held stable while waiting).
  - On mem_ack: if k==LINE_WORDS-1, set k=0 and go to ALLOC; else k++ and go to WB_RD.
- ALLOC: mem_cs=1, mem_we=0, mem_addr={A.tag, idx, k, 0}.
  - On mem_ack: cache_store=1, cache_din=mem_din, cache_addr={A.tag, idx, k, 0} in the same cycle.
  - After the store: if k==LINE_WORDS-1, set k=0 and go to RWAIT; else k++ and stay in ALLOC.
- RWAIT: cache_addr=A with no strobes; go to TAG. The re-check must hit.
  - If it misses again (concurrent external invalidate), repeat the miss path. No deadlock, no assertion.
- Strobes: all array strobes and cpu_ack are single-cycle. cache_store and cache_edit are never asserted together. Memory is never written and read in the same cycle.
- k is LINE_WORDS_WIDTH bits and wraps to 0 after the last word.
- Miss latency, clean victim: 2 + 4·(memlat+1) + 2 cycles.
- Miss latency, dirty victim: adds 4·(memlat+2) cycles.

Test Plan:
- Cold load: after rst, load 0x0000_1040, memory returns 0xA0..0xA3 at words 0..3 with 2-cycle latency.
  - Required: 4 mem reads at 0x1040..0x104C, 4 cache_store pulses.
  - Required: cpu_ack with cpu_dout=0xA0; no mem writes.
- Hit store then load: store 0xDEADBEEF to 0x1044, then load 0x1044.
  - Required: each acks in 2 cycles with no mem activity; load returns 0xDEADBEEF.
- Dirty eviction: after the previous test, load 0x0040_1040 (same index, new tag).
  - Required: 4 mem writes at 0x1040..0x104C, second write data 0xDEADBEEF.
  - Required: then 4 mem reads at 0x0040_1040..; ack after the RWAIT/TAG re-check.
- Clean eviction: load a third tag on the same index without any store.
  - Required: no mem writes, only 4 reads.
- Reset mid-writeback: assert rst during WB_WR with mem_ack withheld.
  - Required: mem_cs=0 next cycle, state IDLE, no cpu_ack, no strobes.
  - Required: a subsequent load completes normally.
- Back-to-back hits: cpu_req held high across 3 hit loads at different words.
  - Required: ack every 2nd cycle; cpu_stall=1 only in TAG cycles.

Source files
------------

// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped, write-back, write-allocate cache
// array: services hits, writes back dirty victims and refills lines on misses.
module cache_ctrl #(
    parameter int ADDR_BITS        = 32,
    parameter int WORD_BITS        = 32,
    parameter int WORD_BYTES_WIDTH = 2,
    parameter int LINE_WORDS_WIDTH = 2,
    parameter int LINE_INDEX_WIDTH = 6,
    parameter int TAG_BITS         = ADDR_BITS - LINE_INDEX_WIDTH - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_ack,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [WORD_BITS-1:0] cache_din,
    input  logic                 cache_hit,
    input  logic [WORD_BITS-1:0] cache_dout,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_dout,
    input  logic [WORD_BITS-1:0] mem_din,
    input  logic                 mem_ack
);
    localparam int IDX_LSB = LINE_WORDS_WIDTH + WORD_BYTES_WIDTH;
    localparam logic [LINE_WORDS_WIDTH-1:0] LAST_K = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_TAG, S_WB_RD, S_WB_WR, S_ALLOC, S_RWAIT
    } state_t;

    state_t                      r_state;
    logic [LINE_WORDS_WIDTH-1:0] r_k;
    logic [ADDR_BITS-1:0]        r_addr;
    logic                        r_we;
    logic [WORD_BITS-1:0]        r_din;
    logic [WORD_BITS-1:0]        r_dout;
    logic [TAG_BITS-1:0]         r_vtag;
    logic                        r_ack;

    logic [TAG_BITS-1:0]         w_atag;
    logic [LINE_INDEX_WIDTH-1:0] w_idx;
    logic [ADDR_BITS-1:0]        w_alloc_addr;
    logic [ADDR_BITS-1:0]        w_wb_addr;
    logic                        w_hit_store;
    logic                        w_fill;

    assign w_atag       = r_addr[ADDR_BITS-1 -: TAG_BITS];
    assign w_idx        = r_addr[IDX_LSB +: LINE_INDEX_WIDTH];
    assign w_alloc_addr = {w_atag, w_idx, r_k, {WORD_BYTES_WIDTH{1'b0}}};
    assign w_wb_addr    = {r_vtag, w_idx, r_k, {WORD_BYTES_WIDTH{1'b0}}};

    // Array strobes fire in the deciding cycle so they pair with the address
    // presented in that same cycle; reset suppresses them immediately.
    assign w_hit_store = !rst && (r_state == S_TAG) && cache_hit && r_we;
    assign w_fill      = !rst && (r_state == S_ALLOC) && mem_ack;

    assign cpu_ack       = r_ack;
    assign cpu_dout      = r_dout;
    assign cpu_stall     = (r_state != S_IDLE);
    assign cache_store   = w_fill;
    assign cache_edit    = w_hit_store;
    assign cache_invalid = 1'b0;
    assign cache_din     = w_fill ? mem_din : (w_hit_store ? r_din : '0);

    assign mem_cs   = (r_state == S_WB_WR) || (r_state == S_ALLOC);
    assign mem_we   = (r_state == S_WB_WR);
    assign mem_dout = (r_state == S_WB_WR) ? cache_dout : '0;

    always_comb begin
        cache_addr = cpu_addr;
        mem_addr   = '0;
        case (r_state)
            S_TAG, S_RWAIT:   cache_addr = r_addr;
            S_WB_RD:          cache_addr = w_wb_addr;
            S_WB_WR: begin
                cache_addr = w_wb_addr;
                mem_addr   = w_wb_addr;
            end
            S_ALLOC: begin
                cache_addr = w_alloc_addr;
                mem_addr   = w_alloc_addr;
            end
            default:          cache_addr = cpu_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_din   <= '0;
            r_dout  <= '0;
            r_vtag  <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_we    <= cpu_we;
                        r_din   <= cpu_din;
                        r_state <= S_TAG;
                    end
                end
                S_TAG: begin
                    if (cache_hit) begin
                        r_ack <= 1'b1;
                        if (!r_we) r_dout <= cache_dout;
                        r_state <= S_IDLE;
                    end else begin
                        r_k <= '0;
                        if (cache_valid && cache_dirty) begin
                            r_vtag  <= cache_tag;
                            r_state <= S_WB_RD;
                        end else begin
                            r_state <= S_ALLOC;
                        end
                    end
                end
                S_WB_RD: r_state <= S_WB_WR;
                S_WB_WR: begin
                    if (mem_ack) begin
                        r_k     <= r_k + 1'b1;
                        r_state <= (r_k == LAST_K) ? S_ALLOC : S_WB_RD;
                    end
                end
                S_ALLOC: begin
                    if (mem_ack) begin
                        r_k <= r_k + 1'b1;
                        if (r_k == LAST_K) r_state <= S_RWAIT;
                    end
                end
                // A re-check miss (line invalidated meanwhile) simply re-enters the miss path.
                S_RWAIT: r_state <= S_TAG;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
